intr_src_unit: RTL
==================

# intr_src_unit

Machine-level interrupt source unit that generates the `excep` interrupt vector consumed by the CSR register file. It contains:
- a 64-bit machine timer with compare;
- an external interrupt input with synchronizer and pending latch;
- a UART interrupt gate.

Software programs it through a small word-addressed register port on the data-memory side. Its output bits 7, 11 and 16 drive the timer, external and UART pending bits of `mip`.

## Interface

Parameters:
- `PRESCALE`, 1 — clk cycles per `mtime` increment; legal range 1..65535.
- `DATA_W`, 32 — bus data width; fixed at 32.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `addr` in 5 — byte address of the register; bits [1:0] are ignored.
- `wr_en` in 1 — register write strobe, one cycle.
- `rd_en` in 1 — register read strobe.
- `wdata` in 32 — write data.
- `rdata` out 32 — read data; combinational from current state; 0 when `rd_en`=0 or the address is unmapped.
- `ext_irq` in 1 — asynchronous external interrupt line.
- `uart_irq` in 1 — level interrupt from the UART, synchronous to `clk`.
- `excep` out 32 — interrupt vector. Bit 7 = timer, bit 11 = external, bit 16 = UART; all other bits are tied to 0.

## Operation

Register map (32-bit):
- 0x00 `MTIME_LO`, 0x04 `MTIME_HI` — read/write.
- 0x08 `MTIMECMP_LO`, 0x0C `MTIMECMP_HI` — read/write.
- 0x10 `IRQ_PEND`:
  - read returns {15'h0, uart, 4'h0, ext, 3'h0, timer, 7'h0} (raw, unmasked);
  - writing 1 to bit 11 clears the external pending latch;
  - other bits ignore writes.
- 0x14 `IRQ_EN` — bits 7, 11, 16 are read/write; all other bits read 0.
- 0x18–0x1C — unmapped; reads return 0, writes are ignored.

Prescaler and timer:
- Prescaler counter `pcnt` (16 bits) counts 0..PRESCALE-1 and wraps to 0.
- `tick` is asserted in the cycle where `pcnt`=PRESCALE-1.
- On `tick`, `mtime` increments as a full 64-bit value; the carry propagates LO→HI, and 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A software write to `MTIME_LO` or `MTIME_HI` in the same cycle as `tick`:
  - the write wins for the written half;
  - the other half is unchanged (no increment, no carry that cycle);
  - `pcnt` is not reset by `mtime` writes.
- Timer pending is a level: unsigned 64-bit `mtime >= mtimecmp`.

External interrupt:
- `ext_irq` passes through a 2-flop synchronizer.
- The pending latch sets on the synchronized event (see Configuration).
- The pending latch clears on a W1C write to bit 11.
- If set and clear occur in the same cycle, set wins.

UART interrupt:
- UART pending is `uart_irq` directly (level); it is cleared at the UART, not here.

Output:
- `excep[b]` = pending[b] & `IRQ_EN[b]`, registered.

## Timing

Reset values:
- `mtime`=0, `pcnt`=0.
- `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, so there is no timer interrupt after reset.
- `IRQ_EN`=0.
- Synchronizer flops = 0, external latch = 0.
- `excep`=0; `rdata`=0 while `rd_en`=0.
- Reset asserted mid-count returns everything to these values immediately; counting resumes on the first rising edge after deassertion.

Latencies:
- Register writes take effect at the rising edge where `wr_en`=1.
- `rdata` reflects state in the same cycle as `rd_en`.
- Timer: `mtime` reaches `mtimecmp` at edge N → `excep[7]` is high after edge N+1.
- External: `ext_irq` rising edge to `excep[11]` is 4 edges (2 sync + 1 latch + 1 output register).
- UART: `uart_irq` to `excep[16]` is 1 edge.
- Enable/clear: a write to `IRQ_EN` or `IRQ_PEND` changes `excep` 1 edge after the write edge.

Timer is a level: `excep[7]` stays high until software raises `mtimecmp` above `mtime` or clears `IRQ_EN[7]`.

Split 64-bit `mtimecmp` update: software writes HI=0xFFFF_FFFF first, then LO, then HI. No hardware atomicity is provided.

## Configuration

`INTR_EXT_EDGE_EN`:
- Defined: the external latch sets on a synchronized 0→1 transition only. A held-high `ext_irq` re-pends only after a low period of at least 1 synchronized cycle.
- Undefined: the external pending bit follows the synchronized level (no latch). W1C on bit 11 has no effect, and `excep[11]` drops 3 edges after `ext_irq` falls (synchronizer + output register).

## Test plan

- **Reset:** drive `reset`=1 mid-run with `mtime`=0x1234 → `mtime` reads 0, `MTIMECMP_LO`/`MTIMECMP_HI` read 0xFFFF_FFFF each, `excep`=0.
- **Timer:** PRESCALE=4, `mtimecmp`=5, `IRQ_EN`=0x80 → `excep[7]` rises 1 edge after `mtime`=5 (about 20 cycles after start); writing `MTIMECMP_LO`=100 drops `excep[7]` one edge later.
- **Carry and collision:** set `mtime`=0x0000_0000_FFFF_FFFF → after one `tick` it reads HI=1, LO=0. Writing LO=7 on the `tick` cycle → LO=7, HI unchanged.
- **External edge (`INTR_EXT_EDGE_EN` defined):**
  - pulse `ext_irq` for 3 cycles with EN bit 11 set → `excep[11]`=1 four edges after the rise and stays high;
  - W1C 0x800 to `IRQ_PEND` → 0 one edge later;
  - a new edge coincident with W1C → remains 1.
- **UART and masking:** `uart_irq`=1 with EN=0 → `IRQ_PEND` reads 0x10000 while `excep`=0; set EN bit 16 → `excep`=0x10000.
- **Bus:** read 0x18 → 0; write 0xFFFF_FFFF to `IRQ_EN` → reads back 0x0001_0880.

Source files
------------

// File: rtl/intr_src_unit.sv
// rtl/intr_src_unit.sv - machine interrupt source unit: 64-bit timer/compare, external latch, UART gate (option INTR_EXT_EDGE_EN)
module intr_src_unit #(
    parameter int PRESCALE = 1,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              ext_irq,
    input  logic              uart_irq,
    output logic [31:0]       excep
);

    // Word indices of the register map (addr[4:2]).
    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_IRQ_PEND    = 3'd4;
    localparam logic [2:0] REG_IRQ_EN      = 3'd5;

    // Bit positions of the three sources in mip/excep.
    localparam int BIT_TIMER = 7;
    localparam int BIT_EXT   = 11;
    localparam int BIT_UART  = 16;

    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [2:0]  reg_idx;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_pend;
    logic        wr_en_reg;

    logic [15:0] pcnt;
    logic        tick;
    logic [31:0] mtime_lo;
    logic [31:0] mtime_hi;
    logic [63:0] mtime_inc;
    logic [31:0] cmp_lo;
    logic [31:0] cmp_hi;
    logic        timer_pend;

    logic        ext_s1;
    logic        ext_s2;
    logic        ext_pend;
    logic        ext_clr;

    logic        uart_pend;

    logic        en_timer;
    logic        en_ext;
    logic        en_uart;

    logic        excep_timer;
    logic        excep_ext;
    logic        excep_uart;

    logic        unused_addr;

    assign reg_idx     = addr[4:2];
    assign unused_addr = &{1'b0, addr[1:0]};

    assign wr_mtime_lo = wr_en && (reg_idx == REG_MTIME_LO);
    assign wr_mtime_hi = wr_en && (reg_idx == REG_MTIME_HI);
    assign wr_cmp_lo   = wr_en && (reg_idx == REG_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && (reg_idx == REG_MTIMECMP_HI);
    assign wr_pend     = wr_en && (reg_idx == REG_IRQ_PEND);
    assign wr_en_reg   = wr_en && (reg_idx == REG_IRQ_EN);

    // ------------------------------------------------------------------
    // Prescaler and 64-bit timer
    // ------------------------------------------------------------------
    assign tick      = (pcnt == PCNT_MAX);
    assign mtime_inc = {mtime_hi, mtime_lo} + 64'd1;

    // Prescaler free-runs 0..PRESCALE-1; mtime writes deliberately do not touch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= 16'd0;
        end else if (tick) begin
            pcnt <= 16'd0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // mtime: a software write owns its half and suppresses the tick for the whole 64 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_lo <= 32'd0;
            mtime_hi <= 32'd0;
        end else if (wr_mtime_lo) begin
            mtime_lo <= wdata;
        end else if (wr_mtime_hi) begin
            mtime_hi <= wdata;
        end else if (tick) begin
            mtime_lo <= mtime_inc[31:0];
            mtime_hi <= mtime_inc[63:32];
        end
    end

    // mtimecmp resets to all ones so no timer interrupt is pending out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_lo <= 32'hFFFF_FFFF;
            cmp_hi <= 32'hFFFF_FFFF;
        end else begin
            if (wr_cmp_lo) begin
                cmp_lo <= wdata;
            end
            if (wr_cmp_hi) begin
                cmp_hi <= wdata;
            end
        end
    end

    assign timer_pend = ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});

    // ------------------------------------------------------------------
    // External interrupt
    // ------------------------------------------------------------------
    assign ext_clr = wr_pend && wdata[BIT_EXT];

    // Two-flop synchronizer for the asynchronous ext_irq line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
        end else begin
            ext_s1 <= ext_irq;
            ext_s2 <= ext_s1;
        end
    end

`ifdef INTR_EXT_EDGE_EN
    logic ext_s3;
    logic ext_rise;

    assign ext_rise = ext_s2 && !ext_s3;

    // Edge-triggered pending latch: a synchronized rise sets it, W1C clears it, set has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_s3   <= 1'b0;
            ext_pend <= 1'b0;
        end else begin
            ext_s3 <= ext_s2;
            if (ext_rise) begin
                ext_pend <= 1'b1;
            end else if (ext_clr) begin
                ext_pend <= 1'b0;
            end
        end
    end
`else
    logic unused_ext_clr;

    assign unused_ext_clr = ext_clr;

    // Level mode: pending simply follows the synchronized line; W1C has nothing to clear.
    always_comb begin
        ext_pend = ext_s2;
    end
`endif

    // ------------------------------------------------------------------
    // UART, enables and registered output vector
    // ------------------------------------------------------------------
    assign uart_pend = uart_irq;

    // IRQ_EN keeps only the three implemented enable bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_timer <= 1'b0;
            en_ext   <= 1'b0;
            en_uart  <= 1'b0;
        end else if (wr_en_reg) begin
            en_timer <= wdata[BIT_TIMER];
            en_ext   <= wdata[BIT_EXT];
            en_uart  <= wdata[BIT_UART];
        end
    end

    // Masked pending bits are registered once before leaving the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            excep_timer <= 1'b0;
            excep_ext   <= 1'b0;
            excep_uart  <= 1'b0;
        end else begin
            excep_timer <= timer_pend && en_timer;
            excep_ext   <= ext_pend && en_ext;
            excep_uart  <= uart_pend && en_uart;
        end
    end

    always_comb begin
        excep            = 32'd0;
        excep[BIT_TIMER] = excep_timer;
        excep[BIT_EXT]   = excep_ext;
        excep[BIT_UART]  = excep_uart;
    end

    // ------------------------------------------------------------------
    // Read mux: combinational, zero when not reading or unmapped
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (reg_idx)
                REG_MTIME_LO:    rdata = mtime_lo;
                REG_MTIME_HI:    rdata = mtime_hi;
                REG_MTIMECMP_LO: rdata = cmp_lo;
                REG_MTIMECMP_HI: rdata = cmp_hi;
                REG_IRQ_PEND: begin
                    rdata[BIT_TIMER] = timer_pend;
                    rdata[BIT_EXT]   = ext_pend;
                    rdata[BIT_UART]  = uart_pend;
                end
                REG_IRQ_EN: begin
                    rdata[BIT_TIMER] = en_timer;
                    rdata[BIT_EXT]   = en_ext;
                    rdata[BIT_UART]  = en_uart;
                end
                default:         rdata = '0;
            endcase
        end
    end

endmodule
